ppc_branch_unit: RTL
====================

// Module: ppc_branch_unit
// PURPOSE
//  Parametrised branch/condition unit for the PPC core: owns LR, CTR and an 8-field CR.
//  Resolves b/ba/bl/bla, bc*, bclr* and bcctr* for the fetch stage in the same cycle.
//  Adds a return-address stack (RAS) that predicts bclr targets and counts mispredicts.
//  Sits beside the GPR file; nextPC = br_taken ? br_target : pc+4.
// PARAMETERS
//  XLEN       64  width of PC, LR, CTR, targets (bit 0 = MSB, PPC numbering)
//  RAS_DEPTH   8  return-address stack entries (power of 2, >=2)
//  CNT_W      16  width of saturating mispredict counter
// PORTS
//  clk           in   1     core clock (all state on posedge)
//  rst_n         in   1     synchronous active-low reset
//  in_valid      in   1     inst/pc valid this cycle; no state change when 0
//  inst          in   32    instruction word [0:31]
//  pc            in   XLEN  address of inst
//  cr_we         in   1     CR field write from execute (add./or. etc.)
//  cr_field      in   3     CR field index 0..7 (field f = cr[4f:4f+3])
//  cr_wdata      in   4     {LT,GT,EQ,SO}
//  spr_we        in   1     mtspr write
//  spr_sel       in   1     0=LR, 1=CTR
//  spr_wdata     in   XLEN  mtspr data
//  br_taken      out  1     branch taken (combinational)
//  br_target     out  XLEN  taken target, low 2 bits forced 0 (combinational)
//  ras_pred_vld  out  1     RAS non-empty
//  ras_pred      out  XLEN  RAS top (predicted bclr target)
//  mispredict    out  1     registered 1-cycle pulse: taken bclr whose target != popped RAS entry
//  mispred_cnt   out  CNT_W saturating count of mispredict pulses
//  lr, ctr       out  XLEN  architected registers; cr out 32
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): lr=ctr=0, cr=0, RAS empty, mispredict=0, mispred_cnt=0;
//   in_valid ignored that cycle. Reset mid-sequence discards all RAS content.
//  Decode (only when in_valid): op18 = B; op16 = BC; op19 xop10=16 BCLR, xop10=528 BCCTR;
//   AA=inst[30], LK=inst[31], BO=inst[6:10], BI=inst[11:15]. Other opcodes: br_taken=0, no update.
//  Targets: B: sext(LI)<<2 (+pc unless AA); BC: sext(BD)<<2 (+pc unless AA);
//   BCLR: {lr[0:XLEN-3],2'b00}; BCCTR: {ctr[0:XLEN-3],2'b00}. All adds modulo 2^XLEN.
//  Condition: ctr_m1=ctr-1; ctr_ok = BO[2] | ((ctr_m1!=0) ^ BO[3]); cond_ok = BO[0] | (cr[BI]==BO[1]).
//   B: taken=1. BC/BCLR: ctr_ok & cond_ok. BCCTR: cond_ok only; BO[2]=0 on BCCTR is treated as BO[2]=1.
//  CTR: BC/BCLR with BO[2]=0 -> ctr <= ctr_m1 (0 wraps to all-ones), whether or not taken.
//  LR: any decoded branch with LK=1 -> lr <= pc+4 (BCLRL uses old lr as target).
//  Priority per register: branch update > spr_we; CR is written only by cr_we.
//  RAS: push pc+4 on LK=1 branch; pop on BCLR with LK=0 that is taken.
//   BCLRL taken: pop+push in the same cycle (top replaced, count unchanged).
//   Push when full: overwrite oldest (circular), count stays RAS_DEPTH.
//   Pop when empty: no-op, count stays 0, no mispredict compare.
//   Not-taken branches never touch the RAS (LK push still happens on not-taken bcl).
//  Mispredict: on pop with non-empty RAS, mispredict <= (ras_pred != br_target) next cycle;
//   mispred_cnt increments with the pulse, holds at 2^CNT_W-1.
//  No backpressure: one instruction per cycle, all updates visible the following cycle.
// TESTING
//  1 reset; pc=0x100, inst=bl +0x40 (0x48000041) -> taken, target=0x140, next cycle lr=0x104, ras_pred=0x104
//  2 ctr=3, bdnz -8 (BO=16) three times -> taken,taken,not-taken; ctr 2,1,0
//  3 cr_we field0=4'b0010 then beq (BO=12,BI=2) -> taken; BI=0 with BO=12 -> not taken
//  4 push RAS_DEPTH+1 bl's, then RAS_DEPTH+1 blr's -> first RAS_DEPTH pops correct, last pop no-op
//  5 mtspr lr=0x200 after bl, then blr -> target 0x200, mispredict=1, mispred_cnt=1
//  6 spr_we ctr=5 same cycle as bdnz with ctr=9 -> ctr=8 (branch wins); rst_n=0 mid-run -> all zero

Source files
------------

// File: rtl/ppc_branch_unit.sv
// ppc_branch_unit
//   Branch/condition unit for the PPC core. Holds LR, CTR and the 8-field CR, resolves
//   b/bc/bclr/bcctr in the cycle they are presented, and keeps a return-address stack (RAS)
//   that predicts bclr targets and counts bclr mispredicts.
// Ports
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_valid, i_inst, i_pc     instruction word (PPC bit 0 = i_inst[31]) and its address
//   i_cr_we/field/wdata       CR field write {LT,GT,EQ,SO} from execute
//   i_spr_we/sel/wdata        mtspr write, sel 0 = LR, 1 = CTR
//   o_br_taken, o_br_target   same-cycle branch resolution
//   o_ras_pred_vld, o_ras_pred  RAS top and its validity
//   o_mispredict, o_mispred_cnt  registered bclr mispredict pulse and saturating count
//   o_lr, o_ctr, o_cr         architected registers
module ppc_branch_unit #(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned RAS_DEPTH = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [31:0]      i_inst,
    input  logic [XLEN-1:0]  i_pc,
    input  logic             i_cr_we,
    input  logic [2:0]       i_cr_field,
    input  logic [3:0]       i_cr_wdata,
    input  logic             i_spr_we,
    input  logic             i_spr_sel,
    input  logic [XLEN-1:0]  i_spr_wdata,
    output logic             o_br_taken,
    output logic [XLEN-1:0]  o_br_target,
    output logic             o_ras_pred_vld,
    output logic [XLEN-1:0]  o_ras_pred,
    output logic             o_mispredict,
    output logic [CNT_W-1:0] o_mispred_cnt,
    output logic [XLEN-1:0]  o_lr,
    output logic [XLEN-1:0]  o_ctr,
    output logic [31:0]      o_cr
);
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned RCW   = PTR_W + 1;
    localparam logic [RCW-1:0]  RAS_FULL = RCW'(RAS_DEPTH);
    localparam logic [XLEN-1:0] ONE      = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] FOUR     = {{(XLEN-3){1'b0}}, 3'b100};

    logic [XLEN-1:0]  r_lr;
    logic [XLEN-1:0]  r_ctr;
    logic [31:0]      r_cr;
    logic [XLEN-1:0]  r_ras [RAS_DEPTH];
    logic [PTR_W-1:0] r_top;
    logic [RCW-1:0]   r_ras_cnt;
    logic             r_mispredict;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic [5:0]       w_op;
    logic [9:0]       w_xop;
    logic [4:0]       w_bo;
    logic [4:0]       w_bi;
    logic             w_aa;
    logic             w_lk;
    logic             w_is_b;
    logic             w_is_bc;
    logic             w_is_bclr;
    logic             w_is_bcctr;
    logic             w_is_br;
    logic [XLEN-1:0]  w_li_ext;
    logic [XLEN-1:0]  w_bd_ext;
    logic [XLEN-1:0]  w_pc4;
    logic [XLEN-1:0]  w_ctr_m1;
    logic             w_ctr_ok;
    logic             w_cond_ok;
    logic             w_dec_ctr;
    logic             w_taken;
    logic [XLEN-1:0]  w_target;
    logic             w_push;
    logic             w_pop;
    logic             w_ras_nonempty;
    logic             w_mis_chk;
    logic [PTR_W-1:0] w_top_inc;
    logic [PTR_W-1:0] w_top_dec;

    // Field extraction; PPC bit k of the instruction is i_inst[31-k].
    assign w_op  = i_inst[31:26];
    assign w_xop = i_inst[10:1];
    assign w_bo  = i_inst[25:21];   // w_bo[4] is BO[0]
    assign w_bi  = i_inst[20:16];
    assign w_aa  = i_inst[1];
    assign w_lk  = i_inst[0];

    assign w_is_b     = i_valid && (w_op == 6'd18);
    assign w_is_bc    = i_valid && (w_op == 6'd16);
    assign w_is_bclr  = i_valid && (w_op == 6'd19) && (w_xop == 10'd16);
    assign w_is_bcctr = i_valid && (w_op == 6'd19) && (w_xop == 10'd528);
    assign w_is_br    = w_is_b || w_is_bc || w_is_bclr || w_is_bcctr;

    assign w_li_ext = {{(XLEN-26){i_inst[25]}}, i_inst[25:2], 2'b00};
    assign w_bd_ext = {{(XLEN-16){i_inst[15]}}, i_inst[15:2], 2'b00};
    assign w_pc4    = i_pc + FOUR;
    assign w_ctr_m1 = r_ctr - ONE;

    assign w_ctr_ok  = w_bo[2] || ((w_ctr_m1 != '0) ^ w_bo[1]);
    assign w_cond_ok = w_bo[4] || (r_cr[5'd31 - w_bi] == w_bo[3]);
    // bcctr never decrements CTR, regardless of BO[2].
    assign w_dec_ctr = (w_is_bc || w_is_bclr) && !w_bo[2];

    always_comb begin
        w_taken  = 1'b0;
        w_target = '0;
        if (w_is_b) begin
            w_taken  = 1'b1;
            w_target = w_li_ext + (w_aa ? '0 : i_pc);
        end else if (w_is_bc) begin
            w_taken  = w_ctr_ok && w_cond_ok;
            w_target = w_bd_ext + (w_aa ? '0 : i_pc);
        end else if (w_is_bclr) begin
            w_taken  = w_ctr_ok && w_cond_ok;
            w_target = r_lr;
        end else if (w_is_bcctr) begin
            w_taken  = w_cond_ok;
            w_target = r_ctr;
        end
    end

    assign w_push         = w_is_br && w_lk;
    assign w_pop          = w_is_bclr && w_taken;
    assign w_ras_nonempty = (r_ras_cnt != '0);
    assign w_mis_chk      = w_pop && w_ras_nonempty;
    assign w_top_inc      = r_top + 1'b1;
    assign w_top_dec      = r_top - 1'b1;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_lr          <= '0;
            r_ctr         <= '0;
            r_cr          <= '0;
            r_top         <= '0;
            r_ras_cnt     <= '0;
            r_mispredict  <= 1'b0;
            r_mispred_cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_ras[i] <= '0;
            end
        end else begin
            if (w_dec_ctr) begin
                r_ctr <= w_ctr_m1;
            end else if (i_spr_we && i_spr_sel) begin
                r_ctr <= i_spr_wdata;
            end

            if (w_push) begin
                r_lr <= w_pc4;
            end else if (i_spr_we && !i_spr_sel) begin
                r_lr <= i_spr_wdata;
            end

            if (i_cr_we) begin
                for (int f = 0; f < 8; f++) begin
                    if (i_cr_field == 3'(f)) begin
                        r_cr[31-4*f -: 4] <= i_cr_wdata;
                    end
                end
            end

            // Taken bclrl on a non-empty stack pops and pushes: just replace the top.
            if (w_push && w_mis_chk) begin
                r_ras[r_top] <= w_pc4;
            end else if (w_push) begin
                r_top            <= w_top_inc;
                r_ras[w_top_inc] <= w_pc4;
                if (r_ras_cnt != RAS_FULL) begin
                    r_ras_cnt <= r_ras_cnt + 1'b1;
                end
            end else if (w_mis_chk) begin
                r_top     <= w_top_dec;
                r_ras_cnt <= r_ras_cnt - 1'b1;
            end

            r_mispredict <= w_mis_chk && (o_ras_pred != o_br_target);
            if (w_mis_chk && (o_ras_pred != o_br_target) && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + 1'b1;
            end
        end
    end

    assign o_br_taken     = w_taken;
    assign o_br_target    = {w_target[XLEN-1:2], 2'b00};
    assign o_ras_pred_vld = w_ras_nonempty;
    assign o_ras_pred     = r_ras[r_top];
    assign o_mispredict   = r_mispredict;
    assign o_mispred_cnt  = r_mispred_cnt;
    assign o_lr           = r_lr;
    assign o_ctr          = r_ctr;
    assign o_cr           = r_cr;

endmodule
